// File: rtl/pipe_stage_elastic.sv
// Two-entry elastic pipeline stage (head + skid) with registered in_ready,
// output stall, synchronous flush and a saturating count of flushed entries.
module pipe_stage_elastic #(
  parameter int unsigned DATA_W       = 128,
  parameter bit          CLR_ON_EMPTY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        count,
  output logic [7:0]        drop_cnt
);

  // Occupancy state; the encoding doubles as the held-entry count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } occ_t;

  occ_t              state;
  occ_t              state_nxt;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] skid;
  logic [DATA_W-1:0] head_nxt;
  logic [DATA_W-1:0] skid_nxt;
  logic [7:0]        drop_nxt;
  logic [8:0]        drop_sum;
  logic              push;
  logic              pop;

  // in_ready comes only from registered state, so there is no
  // combinational path from out_ready back to the producer.
  assign in_ready  = (state != S_FULL);
  assign out_valid = (state != S_EMPTY) && !stall;
  assign count     = state;
  assign out_data  = (CLR_ON_EMPTY && (state == S_EMPTY)) ? '0 : head;

  // Flush overrides every transfer in the same cycle.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Saturating accumulation of the entries thrown away by a flush.
  assign drop_sum = {1'b0, drop_cnt} + {7'd0, count};
  assign drop_nxt = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  // Occupancy and storage next-state selection.
  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    skid_nxt  = skid;
    if (flush) begin
      state_nxt = S_EMPTY;
      head_nxt  = '0;
      skid_nxt  = '0;
    end else begin
      unique case (state)
        S_EMPTY: begin
          if (push) begin
            head_nxt  = in_data;
            state_nxt = S_ONE;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            head_nxt = in_data;
          end else if (push) begin
            skid_nxt  = in_data;
            state_nxt = S_FULL;
          end else if (pop) begin
            state_nxt = S_EMPTY;
            if (CLR_ON_EMPTY) head_nxt = '0;
          end
        end
        S_FULL: begin
          // in_ready is low here, so a pop is the only possible transfer.
          if (pop) begin
            head_nxt  = skid;
            skid_nxt  = '0;
            state_nxt = S_ONE;
          end
        end
        default: begin
          state_nxt = S_EMPTY;
          head_nxt  = '0;
          skid_nxt  = '0;
        end
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_EMPTY;
    else        state <= state_nxt;
  end

  // Head and skid payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      head <= head_nxt;
      skid <= skid_nxt;
    end
  end

  // Flush drop counter; reset clears it without counting the lost entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     drop_cnt <= '0;
    else if (flush) drop_cnt <= drop_nxt;
  end

endmodule

// File: doc/pipe_stage_elastic.md
PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

Interface
- REQ-001: Parameter DATA_W, default 128, SHALL set the payload width in bits; legal range 1..512.
- REQ-002: Parameter CLR_ON_EMPTY, default 1, SHALL force out_data to 0 while the stage is empty when set to 1.
- REQ-003: Port clk, input, 1, SHALL be the single clock; all state updates occur on its rising edge.
- REQ-004: Port rst_n, input, 1, SHALL be the asynchronous, active-low reset.
- REQ-005: Port flush, input, 1, SHALL be the synchronous discard of all held entries.
- REQ-006: Port stall, input, 1, SHALL be a synchronous hold of the output side.
- REQ-007: Port in_valid, input, 1, SHALL indicate that the producer offers in_data.
- REQ-008: Port in_data, input, DATA_W, SHALL carry the producer payload.
- REQ-009: Port in_ready, output, 1, SHALL indicate that the stage can accept a payload this cycle.
- REQ-010: Port out_valid, output, 1, SHALL indicate that out_data is valid to the consumer.
- REQ-011: Port out_data, output, DATA_W, SHALL carry the head payload.
- REQ-012: Port out_ready, input, 1, SHALL indicate that the consumer accepts out_data.
- REQ-013: Port count, output, 2, SHALL report the number of held entries (0..2).
- REQ-014: Port drop_cnt, output, 8, SHALL report the saturating total of entries discarded by flush since reset.

Function
- REQ-015: Storage SHALL be two DATA_W entries: a head entry and a skid entry.
- REQ-016: in_ready SHALL equal (count != 2) and SHALL depend only on registered state, never combinationally on out_ready.
- REQ-017: out_valid SHALL equal (count != 0) AND NOT stall.
- REQ-018: out_data SHALL equal the head entry.
- REQ-019: A push SHALL occur when in_valid && in_ready && !flush.
- REQ-020: A pop SHALL occur when out_valid && out_ready && !flush.
- REQ-021: Latency SHALL be 1 cycle: a payload pushed into an empty stage at edge N is presented at out_data with out_valid=1 (if !stall) after edge N.
- REQ-022: At count=0 with push: the head loads in_data and count becomes 1.
- REQ-023: At count=1 with push and no pop: the skid loads in_data and count becomes 2.
- REQ-024: At count=1 with push and pop: the head loads in_data and count stays 1.
- REQ-025: At count=1 with pop only: count becomes 0, and the head clears to 0 if CLR_ON_EMPTY=1.
- REQ-026: At count=2 with pop: the head loads the skid, count becomes 1, and no push is possible because in_ready=0.
- REQ-027: Ordering SHALL be strict FIFO; no payload SHALL be duplicated or lost except by flush.
- REQ-028: When stall=1, no pop SHALL occur, the head SHALL hold, and pushes are still allowed while count<2.
- REQ-029: When flush=1, at the next edge count becomes 0 and both entries clear to 0.
- REQ-030: When flush=1, any in_data offered in the same cycle SHALL be discarded; flush has priority over push, pop and stall.
- REQ-031: On flush, drop_cnt SHALL add the pre-flush count, saturating at 255.
- REQ-032: When flush and stall are both asserted, flush SHALL win.

Reset
- REQ-033: While rst_n=0, asynchronously: count=0, both entries=0, drop_cnt=0, out_valid=0, in_ready=1, out_data=0.
- REQ-034: Release of rst_n SHALL take effect at the first rising clk edge after deassertion; no push or pop SHALL occur on any edge while rst_n=0.
- REQ-035: Assertion of rst_n mid-transfer SHALL discard held entries without incrementing drop_cnt.

Verification
- REQ-036: Push 0xA5 at count=0 with out_ready=1 -> out_valid=1 and out_data=0xA5 one cycle later; count returns to 0 after the pop.
- REQ-037: out_ready=0, push 0x11 then 0x22 -> count=2 and in_ready=0; raise out_ready -> 0x11 then 0x22 appear in order and in_ready returns to 1 after the first pop.
- REQ-038: count=1 with continuous push and pop, payloads 1..100 -> all 100 are received in order at one payload per cycle, and count stays 1.
- REQ-039: count=2 with stall=1 for 5 cycles and out_ready=1 -> out_valid=0 and no pop occurs; releasing stall -> both payloads drain in order.
- REQ-040: count=2, flush=1 with in_valid=1 -> the next cycle shows count=0, out_data=0, drop_cnt=2, and the offered payload is absent from the output.
- REQ-041: rst_n pulsed low mid-cycle at count=2 -> count=0, out_valid=0 and drop_cnt=0 immediately, with no clock edge required.
